// File: rtl/vxe_axi4_master_biu_if.sv
// Signal bundle between the VxEngine client request/response FIFOs, the BIU and the AXI4 interconnect.
// The master modport is the BIU view; the slave modport is the view of the FIFOs plus the AXI slave.
interface vxe_axi4_master_biu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int CID_WIDTH  = 8
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   M_AXI4_AWID;
  logic [ADDR_WIDTH-1:0] M_AXI4_AWADDR;
  logic [7:0]            M_AXI4_AWLEN;
  logic [2:0]            M_AXI4_AWSIZE;
  logic [1:0]            M_AXI4_AWBURST;
  logic                  M_AXI4_AWLOCK;
  logic [3:0]            M_AXI4_AWCACHE;
  logic [2:0]            M_AXI4_AWPROT;
  logic                  M_AXI4_AWVALID;
  logic                  M_AXI4_AWREADY;

  logic [DATA_WIDTH-1:0] M_AXI4_WDATA;
  logic [STRB_WIDTH-1:0] M_AXI4_WSTRB;
  logic                  M_AXI4_WLAST;
  logic                  M_AXI4_WVALID;
  logic                  M_AXI4_WREADY;

  logic [ID_WIDTH-1:0]   M_AXI4_BID;
  logic [1:0]            M_AXI4_BRESP;
  logic                  M_AXI4_BVALID;
  logic                  M_AXI4_BREADY;

  logic [ID_WIDTH-1:0]   M_AXI4_ARID;
  logic [ADDR_WIDTH-1:0] M_AXI4_ARADDR;
  logic [7:0]            M_AXI4_ARLEN;
  logic [2:0]            M_AXI4_ARSIZE;
  logic [1:0]            M_AXI4_ARBURST;
  logic                  M_AXI4_ARLOCK;
  logic [3:0]            M_AXI4_ARCACHE;
  logic [2:0]            M_AXI4_ARPROT;
  logic                  M_AXI4_ARVALID;
  logic                  M_AXI4_ARREADY;

  logic [ID_WIDTH-1:0]   M_AXI4_RID;
  logic [DATA_WIDTH-1:0] M_AXI4_RDATA;
  logic [1:0]            M_AXI4_RRESP;
  logic                  M_AXI4_RLAST;
  logic                  M_AXI4_RVALID;
  logic                  M_AXI4_RREADY;

  logic [CID_WIDTH-1:0]  biu_awcid;
  logic [ADDR_WIDTH-1:0] biu_awaddr;
  logic [DATA_WIDTH-1:0] biu_awdata;
  logic [STRB_WIDTH-1:0] biu_awstrb;
  logic                  biu_awvalid;
  logic                  biu_awpop;

  logic [CID_WIDTH-1:0]  biu_bcid;
  logic [1:0]            biu_bresp;
  logic                  biu_bpush;
  logic                  biu_bready;

  logic [CID_WIDTH-1:0]  biu_arcid;
  logic [ADDR_WIDTH-1:0] biu_araddr;
  logic                  biu_arvalid;
  logic                  biu_arpop;

  logic [CID_WIDTH-1:0]  biu_rcid;
  logic [DATA_WIDTH-1:0] biu_rdata;
  logic [1:0]            biu_rresp;
  logic                  biu_rpush;
  logic                  biu_rready;

  modport master (
    output M_AXI4_AWID, M_AXI4_AWADDR, M_AXI4_AWLEN, M_AXI4_AWSIZE, M_AXI4_AWBURST,
           M_AXI4_AWLOCK, M_AXI4_AWCACHE, M_AXI4_AWPROT, M_AXI4_AWVALID,
    input  M_AXI4_AWREADY,
    output M_AXI4_WDATA, M_AXI4_WSTRB, M_AXI4_WLAST, M_AXI4_WVALID,
    input  M_AXI4_WREADY,
    input  M_AXI4_BID, M_AXI4_BRESP, M_AXI4_BVALID,
    output M_AXI4_BREADY,
    output M_AXI4_ARID, M_AXI4_ARADDR, M_AXI4_ARLEN, M_AXI4_ARSIZE, M_AXI4_ARBURST,
           M_AXI4_ARLOCK, M_AXI4_ARCACHE, M_AXI4_ARPROT, M_AXI4_ARVALID,
    input  M_AXI4_ARREADY,
    input  M_AXI4_RID, M_AXI4_RDATA, M_AXI4_RRESP, M_AXI4_RLAST, M_AXI4_RVALID,
    output M_AXI4_RREADY,
    input  biu_awcid, biu_awaddr, biu_awdata, biu_awstrb, biu_awvalid,
    output biu_awpop,
    output biu_bcid, biu_bresp, biu_bpush,
    input  biu_bready,
    input  biu_arcid, biu_araddr, biu_arvalid,
    output biu_arpop,
    output biu_rcid, biu_rdata, biu_rresp, biu_rpush,
    input  biu_rready
  );

  modport slave (
    input  M_AXI4_AWID, M_AXI4_AWADDR, M_AXI4_AWLEN, M_AXI4_AWSIZE, M_AXI4_AWBURST,
           M_AXI4_AWLOCK, M_AXI4_AWCACHE, M_AXI4_AWPROT, M_AXI4_AWVALID,
    output M_AXI4_AWREADY,
    input  M_AXI4_WDATA, M_AXI4_WSTRB, M_AXI4_WLAST, M_AXI4_WVALID,
    output M_AXI4_WREADY,
    output M_AXI4_BID, M_AXI4_BRESP, M_AXI4_BVALID,
    input  M_AXI4_BREADY,
    input  M_AXI4_ARID, M_AXI4_ARADDR, M_AXI4_ARLEN, M_AXI4_ARSIZE, M_AXI4_ARBURST,
           M_AXI4_ARLOCK, M_AXI4_ARCACHE, M_AXI4_ARPROT, M_AXI4_ARVALID,
    output M_AXI4_ARREADY,
    output M_AXI4_RID, M_AXI4_RDATA, M_AXI4_RRESP, M_AXI4_RLAST, M_AXI4_RVALID,
    input  M_AXI4_RREADY,
    output biu_awcid, biu_awaddr, biu_awdata, biu_awstrb, biu_awvalid,
    input  biu_awpop,
    input  biu_bcid, biu_bresp, biu_bpush,
    output biu_bready,
    output biu_arcid, biu_araddr, biu_arvalid,
    input  biu_arpop,
    input  biu_rcid, biu_rdata, biu_rresp, biu_rpush,
    output biu_rready
  );
endinterface

// File: rtl/vxe_axi4_master_biu.sv
// AXI4 master BIU: single-word client FIFO requests become single-beat AXI4 transactions.
// Write and read paths are independent, each with at most one transaction outstanding.
//
// state  | meaning
// W_IDLE | waiting for a write request; pops the client FIFO in the same cycle
// W_REQ  | AWVALID and WVALID presented, each dropped on its own handshake
// W_RESP | BREADY follows the client FIFO; B handshake pushes the response
// R_IDLE | waiting for a read request; pops the client FIFO in the same cycle
// R_REQ  | ARVALID presented until ARREADY
// R_RESP | RREADY follows the client FIFO; every beat is pushed, RLAST ends it
module vxe_axi4_master_biu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int CID_WIDTH  = 8
) (
  input logic                   M_AXI4_ACLK,
  input logic                   M_AXI4_ARESET,
  vxe_axi4_master_biu_if.master bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int MAP_WIDTH  = (ID_WIDTH < CID_WIDTH) ? ID_WIDTH : CID_WIDTH;
  localparam logic [2:0] AX_SIZE = 3'($clog2(STRB_WIDTH));

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_RESP = 2'd2
  } r_state_t;

  // Client IDs and AXI IDs are zero-extended or truncated in both directions.
  function automatic logic [ID_WIDTH-1:0] cid_to_id(input logic [CID_WIDTH-1:0] cid);
    logic [ID_WIDTH-1:0] id;
    id = '0;
    id[MAP_WIDTH-1:0] = cid[MAP_WIDTH-1:0];
    return id;
  endfunction

  function automatic logic [CID_WIDTH-1:0] id_to_cid(input logic [ID_WIDTH-1:0] id);
    logic [CID_WIDTH-1:0] cid;
    cid = '0;
    cid[MAP_WIDTH-1:0] = id[MAP_WIDTH-1:0];
    return cid;
  endfunction

  w_state_t              w_state, w_state_nxt;
  logic [ID_WIDTH-1:0]   aw_id_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  w_pop;
  logic                  bready_c;
  logic                  b_hs;
  logic                  w_req_done;

  r_state_t              r_state, r_state_nxt;
  logic [ID_WIDTH-1:0]   ar_id_q;
  logic [ADDR_WIDTH-1:0] ar_addr_q;
  logic                  arvalid_q;
  logic                  r_pop;
  logic                  rready_c;
  logic                  r_hs;

  // A channel counts as done if it already handshook or is handshaking this cycle.
  assign w_req_done = (~awvalid_q | bus.M_AXI4_AWREADY) & (~wvalid_q | bus.M_AXI4_WREADY);

  always_ff @(posedge M_AXI4_ACLK or posedge M_AXI4_ARESET) begin
    if (M_AXI4_ARESET) begin
      w_state <= W_IDLE;
    end else begin
      w_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE: if (w_pop) w_state_nxt = W_REQ;
      W_REQ:  if (w_req_done) w_state_nxt = W_RESP;
      W_RESP: if (b_hs) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_pop    = 1'b0;
    bready_c = 1'b0;
    case (w_state)
      W_IDLE: w_pop = bus.biu_awvalid & ~M_AXI4_ARESET;
      W_RESP: bready_c = bus.biu_bready;
      default: ;
    endcase
    b_hs = bus.M_AXI4_BVALID & bready_c;
  end

  always_ff @(posedge M_AXI4_ACLK or posedge M_AXI4_ARESET) begin
    if (M_AXI4_ARESET) begin
      aw_id_q   <= '0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
    end else if (w_pop) begin
      aw_id_q   <= cid_to_id(bus.biu_awcid);
      aw_addr_q <= bus.biu_awaddr;
      w_data_q  <= bus.biu_awdata;
      w_strb_q  <= bus.biu_awstrb;
      awvalid_q <= 1'b1;
      wvalid_q  <= 1'b1;
    end else begin
      if (bus.M_AXI4_AWREADY) awvalid_q <= 1'b0;
      if (bus.M_AXI4_WREADY)  wvalid_q  <= 1'b0;
    end
  end

  assign bus.M_AXI4_AWID    = aw_id_q;
  assign bus.M_AXI4_AWADDR  = aw_addr_q;
  assign bus.M_AXI4_AWLEN   = 8'd0;
  assign bus.M_AXI4_AWSIZE  = AX_SIZE;
  assign bus.M_AXI4_AWBURST = 2'b01;
  assign bus.M_AXI4_AWLOCK  = 1'b0;
  assign bus.M_AXI4_AWCACHE = 4'b0000;
  assign bus.M_AXI4_AWPROT  = 3'b000;
  assign bus.M_AXI4_AWVALID = awvalid_q;
  assign bus.M_AXI4_WDATA   = w_data_q;
  assign bus.M_AXI4_WSTRB   = w_strb_q;
  assign bus.M_AXI4_WLAST   = 1'b1;
  assign bus.M_AXI4_WVALID  = wvalid_q;
  assign bus.M_AXI4_BREADY  = bready_c;
  assign bus.biu_awpop      = w_pop;
  assign bus.biu_bpush      = b_hs;
  assign bus.biu_bcid       = id_to_cid(bus.M_AXI4_BID);
  assign bus.biu_bresp      = bus.M_AXI4_BRESP;

  always_ff @(posedge M_AXI4_ACLK or posedge M_AXI4_ARESET) begin
    if (M_AXI4_ARESET) begin
      r_state <= R_IDLE;
    end else begin
      r_state <= r_state_nxt;
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE: if (r_pop) r_state_nxt = R_REQ;
      R_REQ:  if (bus.M_AXI4_ARREADY) r_state_nxt = R_RESP;
      R_RESP: if (r_hs && bus.M_AXI4_RLAST) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    r_pop    = 1'b0;
    rready_c = 1'b0;
    case (r_state)
      R_IDLE: r_pop = bus.biu_arvalid & ~M_AXI4_ARESET;
      R_RESP: rready_c = bus.biu_rready;
      default: ;
    endcase
    r_hs = bus.M_AXI4_RVALID & rready_c;
  end

  always_ff @(posedge M_AXI4_ACLK or posedge M_AXI4_ARESET) begin
    if (M_AXI4_ARESET) begin
      ar_id_q   <= '0;
      ar_addr_q <= '0;
      arvalid_q <= 1'b0;
    end else if (r_pop) begin
      ar_id_q   <= cid_to_id(bus.biu_arcid);
      ar_addr_q <= bus.biu_araddr;
      arvalid_q <= 1'b1;
    end else if (bus.M_AXI4_ARREADY) begin
      arvalid_q <= 1'b0;
    end
  end

  assign bus.M_AXI4_ARID    = ar_id_q;
  assign bus.M_AXI4_ARADDR  = ar_addr_q;
  assign bus.M_AXI4_ARLEN   = 8'd0;
  assign bus.M_AXI4_ARSIZE  = AX_SIZE;
  assign bus.M_AXI4_ARBURST = 2'b01;
  assign bus.M_AXI4_ARLOCK  = 1'b0;
  assign bus.M_AXI4_ARCACHE = 4'b0000;
  assign bus.M_AXI4_ARPROT  = 3'b000;
  assign bus.M_AXI4_ARVALID = arvalid_q;
  assign bus.M_AXI4_RREADY  = rready_c;
  assign bus.biu_arpop      = r_pop;
  assign bus.biu_rpush      = r_hs;
  assign bus.biu_rcid       = id_to_cid(bus.M_AXI4_RID);
  assign bus.biu_rdata      = bus.M_AXI4_RDATA;
  assign bus.biu_rresp      = bus.M_AXI4_RRESP;
endmodule

// File: tb/tb_vxe_axi4_master_biu.sv
// Randomized bench for vxe_axi4_master_biu: client FIFO and AXI slave models feed a scoreboard
// whose expectations are pushed when each request is generated.
module tb_vxe_axi4_master_biu;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int IW      = 8;
  localparam int CW      = 8;
  localparam int SW      = DW / 8;
  localparam int N_WR    = 40;
  localparam int N_RD    = 40;
  localparam int MAX_CYC = 20000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vxe_axi4_master_biu_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .CID_WIDTH(CW)) bus ();

  vxe_axi4_master_biu #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .CID_WIDTH(CW)) dut (
    .M_AXI4_ACLK  (clk),
    .M_AXI4_ARESET(rst),
    .bus          (bus.master)
  );

  typedef struct packed {
    logic [CW-1:0] cid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } wreq_t;

  typedef struct packed {
    logic [CW-1:0] cid;
    logic [AW-1:0] addr;
  } rreq_t;

  wreq_t              wr_fifo[$];
  rreq_t              rd_fifo[$];
  logic [60:0]        exp_aw_q[$];
  logic [60:0]        exp_ar_q[$];
  logic [DW+SW:0]     exp_w_q[$];
  logic [CW+1:0]      exp_b_q[$];
  logic [CW+DW+1:0]   exp_r_q[$];
  logic [IW+1:0]      sl_b_q[$];
  logic [IW+DW+1:0]   sl_r_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int wr_gen = 0, rd_gen = 0, wr_done = 0, rd_done = 0;
  int aw_hs = 0, w_hs = 0, ar_hs = 0, b_sent = 0, r_sent = 0;
  bit mon_en = 0, hold = 0, pop_w = 0, pop_r = 0, b_hs = 0, r_hs = 0;
  bit w_busy = 0, r_busy = 0, lat_w = 0, lat_r = 0;
  bit prev_aw = 0, prev_w = 0, prev_ar = 0;
  logic [60:0]    prev_aw_vec, prev_ar_vec;
  logic [DW+SW:0] prev_w_vec;

  logic [60:0]    aw_now, ar_now;
  logic [DW+SW:0] w_now;
  assign aw_now = {bus.M_AXI4_AWID, bus.M_AXI4_AWADDR, bus.M_AXI4_AWLEN, bus.M_AXI4_AWSIZE,
                   bus.M_AXI4_AWBURST, bus.M_AXI4_AWLOCK, bus.M_AXI4_AWCACHE, bus.M_AXI4_AWPROT};
  assign ar_now = {bus.M_AXI4_ARID, bus.M_AXI4_ARADDR, bus.M_AXI4_ARLEN, bus.M_AXI4_ARSIZE,
                   bus.M_AXI4_ARBURST, bus.M_AXI4_ARLOCK, bus.M_AXI4_ARCACHE, bus.M_AXI4_ARPROT};
  assign w_now  = {bus.M_AXI4_WDATA, bus.M_AXI4_WSTRB, bus.M_AXI4_WLAST};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Single-beat INCR, 4-byte size, all other attributes zero; ID is the client ID.
  task automatic gen_write();
    wreq_t r;
    logic [1:0] resp;
    r.cid  = CW'($urandom);
    r.addr = AW'($urandom);
    r.data = DW'($urandom);
    r.strb = SW'($urandom);
    resp   = 2'($urandom);
    if (wr_gen == 0) begin
      r.cid = 8'hfe; r.addr = 32'h0000_000c; r.data = 32'hfefe_fafa; r.strb = '1; resp = 2'b00;
    end else if (wr_gen == 1) begin
      r.cid = 8'hfc; r.data = 32'hdede_dada; r.strb = '1; resp = 2'b00;
    end
    wr_fifo.push_back(r);
    exp_aw_q.push_back({IW'(r.cid), r.addr, 8'd0, 3'd2, 2'b01, 1'b0, 4'd0, 3'd0});
    exp_w_q.push_back({r.data, r.strb, 1'b1});
    sl_b_q.push_back({IW'(r.cid), resp});
    exp_b_q.push_back({r.cid, resp});
    wr_gen++;
  endtask

  task automatic gen_read();
    rreq_t r;
    logic [DW-1:0] data;
    logic [1:0] resp;
    r.cid  = CW'($urandom);
    r.addr = AW'($urandom);
    data   = DW'($urandom);
    resp   = 2'($urandom);
    if (rd_gen == 0) begin
      r.cid = 8'hfa; r.addr = 32'h0000_000b; data = 32'hfefe_fafa; resp = 2'b00;
    end else if (rd_gen == 1) begin
      r.cid = 8'hfd; data = 32'hdede_dada; resp = 2'b00;
    end
    rd_fifo.push_back(r);
    exp_ar_q.push_back({IW'(r.cid), r.addr, 8'd0, 3'd2, 2'b01, 1'b0, 4'd0, 3'd0});
    sl_r_q.push_back({IW'(r.cid), data, resp});
    exp_r_q.push_back({r.cid, data, resp});
    rd_gen++;
  endtask

  // Called just after each rising edge: client FIFOs, client readiness and the AXI slave.
  task automatic drive_cycle();
    if (pop_w) begin wr_fifo.delete(0); pop_w = 0; end
    if (pop_r) begin rd_fifo.delete(0); pop_r = 0; end
    if (wr_gen < N_WR && wr_fifo.size() < 2 && $urandom_range(0, 2) != 0) gen_write();
    if (rd_gen < N_RD && rd_fifo.size() < 2 && $urandom_range(0, 2) != 0) gen_read();
    bus.biu_awvalid = (wr_fifo.size() != 0);
    if (wr_fifo.size() != 0) begin
      bus.biu_awcid  = wr_fifo[0].cid;
      bus.biu_awaddr = wr_fifo[0].addr;
      bus.biu_awdata = wr_fifo[0].data;
      bus.biu_awstrb = wr_fifo[0].strb;
    end
    bus.biu_arvalid = (rd_fifo.size() != 0);
    if (rd_fifo.size() != 0) begin
      bus.biu_arcid  = rd_fifo[0].cid;
      bus.biu_araddr = rd_fifo[0].addr;
    end
    bus.biu_bready = ($urandom_range(0, 9) < 7);
    bus.biu_rready = ($urandom_range(0, 9) < 7);
    bus.M_AXI4_AWREADY = !hold && ($urandom_range(0, 3) != 0);
    bus.M_AXI4_WREADY  = !hold && ($urandom_range(0, 3) != 0);
    bus.M_AXI4_ARREADY = !hold && ($urandom_range(0, 3) != 0);
    if (b_hs) begin bus.M_AXI4_BVALID = 1'b0; b_hs = 0; end
    if (!bus.M_AXI4_BVALID && b_sent < aw_hs && b_sent < w_hs && sl_b_q.size() != 0 &&
        $urandom_range(0, 1) == 1) begin
      {bus.M_AXI4_BID, bus.M_AXI4_BRESP} = sl_b_q.pop_front();
      bus.M_AXI4_BVALID = 1'b1;
      b_sent++;
    end
    if (r_hs) begin bus.M_AXI4_RVALID = 1'b0; r_hs = 0; end
    if (!bus.M_AXI4_RVALID && r_sent < ar_hs && sl_r_q.size() != 0 &&
        $urandom_range(0, 1) == 1) begin
      {bus.M_AXI4_RID, bus.M_AXI4_RDATA, bus.M_AXI4_RRESP} = sl_r_q.pop_front();
      bus.M_AXI4_RLAST  = 1'b1;
      bus.M_AXI4_RVALID = 1'b1;
      r_sent++;
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (lat_w) begin
        check("aw_w_latency", 128'({bus.M_AXI4_AWVALID, bus.M_AXI4_WVALID}), 128'(2'b11));
        lat_w = 0;
      end
      if (lat_r) begin
        check("ar_latency", 128'(bus.M_AXI4_ARVALID), 128'(1'b1));
        lat_r = 0;
      end
      if (bus.biu_awvalid && !w_busy) check("awpop_idle", 128'(bus.biu_awpop), 128'(1'b1));
      if (bus.biu_arvalid && !r_busy) check("arpop_idle", 128'(bus.biu_arpop), 128'(1'b1));
      if (!bus.biu_bready || !w_busy) check("bready_low", 128'(bus.M_AXI4_BREADY), 128'(1'b0));
      if (!bus.biu_rready || !r_busy) check("rready_low", 128'(bus.M_AXI4_RREADY), 128'(1'b0));
      if (bus.M_AXI4_BVALID && bus.biu_bready) check("bready_resp", 128'(bus.M_AXI4_BREADY), 128'(1'b1));
      if (bus.M_AXI4_RVALID && bus.biu_rready) check("rready_resp", 128'(bus.M_AXI4_RREADY), 128'(1'b1));
      if (bus.biu_awpop) begin
        check("awpop_busy", 128'(w_busy), 128'(1'b0));
        w_busy = 1; pop_w = 1; lat_w = 1;
      end
      if (bus.biu_arpop) begin
        check("arpop_busy", 128'(r_busy), 128'(1'b0));
        r_busy = 1; pop_r = 1; lat_r = 1;
      end
      if (prev_aw) check("aw_stable", 128'({bus.M_AXI4_AWVALID, aw_now}), 128'({1'b1, prev_aw_vec}));
      if (prev_w)  check("w_stable", 128'({bus.M_AXI4_WVALID, w_now}), 128'({1'b1, prev_w_vec}));
      if (prev_ar) check("ar_stable", 128'({bus.M_AXI4_ARVALID, ar_now}), 128'({1'b1, prev_ar_vec}));
      prev_aw = bus.M_AXI4_AWVALID && !bus.M_AXI4_AWREADY; prev_aw_vec = aw_now;
      prev_w  = bus.M_AXI4_WVALID && !bus.M_AXI4_WREADY;   prev_w_vec  = w_now;
      prev_ar = bus.M_AXI4_ARVALID && !bus.M_AXI4_ARREADY; prev_ar_vec = ar_now;
      if (bus.M_AXI4_AWVALID && bus.M_AXI4_AWREADY) begin
        check("aw_expected", 128'(exp_aw_q.size() != 0), 128'(1'b1));
        if (exp_aw_q.size() != 0) check("aw_fields", 128'(aw_now), 128'(exp_aw_q.pop_front()));
        aw_hs++;
      end
      if (bus.M_AXI4_WVALID && bus.M_AXI4_WREADY) begin
        check("w_expected", 128'(exp_w_q.size() != 0), 128'(1'b1));
        if (exp_w_q.size() != 0) check("w_fields", 128'(w_now), 128'(exp_w_q.pop_front()));
        w_hs++;
      end
      if (bus.M_AXI4_ARVALID && bus.M_AXI4_ARREADY) begin
        check("ar_expected", 128'(exp_ar_q.size() != 0), 128'(1'b1));
        if (exp_ar_q.size() != 0) check("ar_fields", 128'(ar_now), 128'(exp_ar_q.pop_front()));
        ar_hs++;
      end
      if (bus.biu_bpush || (bus.M_AXI4_BVALID && bus.M_AXI4_BREADY))
        check("bpush_hs", 128'(bus.biu_bpush), 128'(bus.M_AXI4_BVALID && bus.M_AXI4_BREADY));
      if (bus.M_AXI4_BVALID && bus.M_AXI4_BREADY) b_hs = 1;
      if (bus.biu_bpush) begin
        check("b_expected", 128'(exp_b_q.size() != 0), 128'(1'b1));
        if (exp_b_q.size() != 0)
          check("b_fields", 128'({bus.biu_bcid, bus.biu_bresp}), 128'(exp_b_q.pop_front()));
        w_busy = 0; wr_done++;
      end
      if (bus.biu_rpush || (bus.M_AXI4_RVALID && bus.M_AXI4_RREADY))
        check("rpush_hs", 128'(bus.biu_rpush), 128'(bus.M_AXI4_RVALID && bus.M_AXI4_RREADY));
      if (bus.M_AXI4_RVALID && bus.M_AXI4_RREADY) r_hs = 1;
      if (bus.biu_rpush) begin
        check("r_expected", 128'(exp_r_q.size() != 0), 128'(1'b1));
        if (exp_r_q.size() != 0)
          check("r_fields", 128'({bus.biu_rcid, bus.biu_rdata, bus.biu_rresp}), 128'(exp_r_q.pop_front()));
        r_busy = 0; rd_done++;
      end
    end
  end

  initial begin
    int cyc;
    bus.biu_awcid = '0; bus.biu_awaddr = '0; bus.biu_awdata = '0; bus.biu_awstrb = '0;
    bus.biu_awvalid = 1'b0; bus.biu_bready = 1'b0;
    bus.biu_arcid = '0; bus.biu_araddr = '0; bus.biu_arvalid = 1'b0; bus.biu_rready = 1'b0;
    bus.M_AXI4_AWREADY = 1'b0; bus.M_AXI4_WREADY = 1'b0; bus.M_AXI4_ARREADY = 1'b0;
    bus.M_AXI4_BID = '0; bus.M_AXI4_BRESP = '0; bus.M_AXI4_BVALID = 1'b0;
    bus.M_AXI4_RID = '0; bus.M_AXI4_RDATA = '0; bus.M_AXI4_RRESP = '0;
    bus.M_AXI4_RLAST = 1'b0; bus.M_AXI4_RVALID = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", 128'({bus.M_AXI4_AWVALID, bus.M_AXI4_WVALID, bus.M_AXI4_ARVALID,
                              bus.M_AXI4_BREADY, bus.M_AXI4_RREADY, bus.biu_awpop, bus.biu_arpop,
                              bus.biu_bpush, bus.biu_rpush}), 128'(9'd0));
    check("reset_regs", 128'({bus.M_AXI4_AWID, bus.M_AXI4_AWADDR, bus.M_AXI4_WSTRB,
                              bus.M_AXI4_ARID, bus.M_AXI4_ARADDR}), 128'(0));
    check("reset_wdata", 128'(bus.M_AXI4_WDATA), 128'(0));

    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1;
    drive_cycle();
    cyc = 0;
    while ((wr_done < N_WR || rd_done < N_RD) && cyc < MAX_CYC) begin
      @(posedge clk); #1;
      drive_cycle();
      cyc++;
    end
    check("wr_done", 128'(wr_done), 128'(N_WR));
    check("rd_done", 128'(rd_done), 128'(N_RD));
    check("queues_drained", 128'(exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size() +
                                  exp_b_q.size() + exp_r_q.size()), 128'(0));

    // Abort a write mid-request: AWREADY/WREADY held low so AWVALID stays pending.
    hold = 1;
    gen_write();
    for (int i = 0; i < 10 && !bus.M_AXI4_AWVALID; i++) begin
      @(posedge clk); #1;
      drive_cycle();
      @(negedge clk);
    end
    check("rst_pre_awvalid", 128'(bus.M_AXI4_AWVALID), 128'(1'b1));
    mon_en = 0;
    bus.biu_awvalid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_abort_ctrl", 128'({bus.M_AXI4_AWVALID, bus.M_AXI4_WVALID, bus.M_AXI4_ARVALID,
                                  bus.M_AXI4_BREADY, bus.M_AXI4_RREADY, bus.biu_awpop, bus.biu_arpop,
                                  bus.biu_bpush, bus.biu_rpush}), 128'(9'd0));
    check("rst_abort_regs", 128'({bus.M_AXI4_AWID, bus.M_AXI4_AWADDR, bus.M_AXI4_WDATA}), 128'(0));
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_back_idle", 128'({bus.biu_awpop, bus.M_AXI4_AWVALID}), 128'(2'b10));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
